// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - request handshake and single-port memory bus of the ALU execute stage
//
// Request side (requester -> stage):
//   req_valid, req_op[3:0], req_source[15:0], req_dst_addr[15:0], req_store
//   req_ready (stage -> requester)
// Memory side (stage -> memory):
//   mem_addr[15:0], mem_read, mem_write, mem_wdata[15:0]
//   mem_rdata[15:0] (memory -> stage, valid the cycle after mem_read)
// Modports: slave = the execute stage, master = requester plus memory.

interface alu_exec_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_source;
  logic [15:0] req_dst_addr;
  logic        req_store;

  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_source, req_dst_addr, req_store, mem_rdata,
    output req_ready, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_op, req_source, req_dst_addr, req_store, mem_rdata,
    input  req_ready, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - multi-cycle ALU execute stage with memory operand fetch and write-back
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   bus (slave)            request handshake and single-port memory request
//   alu_source/destination/op/flags  combinational operands to an external ALU (0 outside EXEC)
//   alu_result, alu_flags_in, alu_write_flags  combinational results from the external ALU
//   flags_wr_en, flags_wr_data  external load of the flags register
//   flags                  architectural flags register
//   done                   one-cycle retirement pulse
// Parameter FAST_UNARY: when nonzero, source-only op codes skip the destination read.

module alu_exec_stage #(
  parameter int unsigned FAST_UNARY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  alu_exec_stage_if.slave        bus,
  output logic [15:0]            alu_source,
  output logic [15:0]            alu_destination,
  output logic [3:0]             alu_op,
  output logic [15:0]            alu_flags,
  input  logic [15:0]            alu_result,
  input  logic [15:0]            alu_flags_in,
  input  logic                   alu_write_flags,
  input  logic                   flags_wr_en,
  input  logic [15:0]            flags_wr_data,
  output logic [15:0]            flags,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [3:0]  op_q;
  logic [15:0] src_q;
  logic [15:0] dst_addr_q;
  logic        store_q;
  logic [15:0] dst_q;
  logic [15:0] res_q;
  logic [15:0] flags_q;

  logic        accept;
  logic        skip_read;

  // Op codes whose result depends on the source operand only.
  function automatic logic is_unary(input logic [3:0] op);
    case (op)
      4'd0, 4'd4, 4'd7, 4'd8, 4'd9: is_unary = 1'b1;
      default:                      is_unary = 1'b0;
    endcase
  endfunction

  assign accept    = bus.req_valid && (state == IDLE);
  assign skip_read = (FAST_UNARY != 0) && is_unary(bus.req_op);
  assign flags     = flags_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      src_q      <= '0;
      dst_addr_q <= '0;
      store_q    <= 1'b0;
      dst_q      <= '0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        op_q       <= bus.req_op;
        src_q      <= bus.req_source;
        dst_addr_q <= bus.req_dst_addr;
        store_q    <= bus.req_store;
        // Fast-path ops never fetch, so their destination operand is zero;
        // the full path overwrites this in WAIT.
        dst_q      <= '0;
      end

      if (state == WAIT) begin
        dst_q <= bus.mem_rdata;
      end

      if (state == EXEC) begin
        res_q <= alu_result;
      end

      // The ALU update outranks a coincident external load.
      if ((state == EXEC) && alu_write_flags) begin
        flags_q <= alu_flags_in;
      end else if (flags_wr_en) begin
        flags_q <= flags_wr_data;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wdata   = '0;
    alu_source      = '0;
    alu_destination = '0;
    alu_op          = '0;
    alu_flags       = '0;
    done            = 1'b0;

    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_nxt = skip_read ? EXEC : READ;
        end
      end

      READ: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = dst_addr_q;
        state_nxt    = WAIT;
      end

      WAIT: begin
        state_nxt = EXEC;
      end

      EXEC: begin
        alu_source      = src_q;
        alu_destination = dst_q;
        alu_op          = op_q;
        alu_flags       = flags_q;
        state_nxt       = WRITE;
      end

      WRITE: begin
        // A reset arriving in the retire cycle suppresses the write and the pulse.
        done = !reset;
        if (store_q && !reset) begin
          bus.mem_write = 1'b1;
          bus.mem_addr  = dst_addr_q;
          bus.mem_wdata = res_q;
        end
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 The block SHALL have a parameter FAST_UNARY, default 1; when 1, source-only op codes skip the destination memory read.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, on the ports listed in REQ-003 and REQ-004.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  operation request present.
REQ-006 req_ready  out  1  stage can accept a request.
REQ-007 req_op  in  4  ALU op code.
REQ-008 req_source  in  16  resolved source operand value.
REQ-009 req_dst_addr  in  16  destination memory address.
REQ-010 req_store  in  1  write result back to memory (0 = flags-only operation).
REQ-011 mem_addr  out  16 / mem_read  out  1 / mem_write  out  1 / mem_wdata  out  16: single-port memory request.
REQ-012 mem_rdata  in  16  read data, valid the cycle after mem_read.
REQ-013 alu_source  out  16 / alu_destination  out  16 / alu_op  out  4 / alu_flags  out  16: combinational ALU operands.
REQ-014 alu_result  in  16 / alu_flags_in  in  16 / alu_write_flags  in  1: combinational ALU outputs.
REQ-015 flags_wr_en  in  1 / flags_wr_data  in  16: external flags-register load.
REQ-016 flags  out  16  architectural flags register.
REQ-017 done  out  1  one-cycle pulse marking operation retirement.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WAIT, EXEC and WRITE.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid & req_ready, which latches op, source, dst_addr and store.
REQ-020 On accept, the next state SHALL be READ, or EXEC when FAST_UNARY=1 and op is in {0,4,7,8,9}; for those skipped ops the latched destination SHALL be 0.
REQ-021 In READ: mem_read=1, mem_addr=dst_addr, then go to WAIT.
REQ-022 In WAIT: latch mem_rdata as the destination operand, then go to EXEC.
REQ-023 In EXEC: drive the ALU ports from the latched op, source and destination, with alu_flags = flags; latch alu_result; if alu_write_flags=1, load flags from alu_flags_in; then go to WRITE.
REQ-024 In WRITE: done=1; mem_write=store; mem_addr=dst_addr; mem_wdata = latched result; then go to IDLE.
REQ-025 Latency from accept edge to done SHALL be 4 cycles (full path) or 2 cycles (fast path); maximum throughput is one operation per 5 or 3 cycles.
REQ-026 mem_read and mem_write SHALL never both be 1, and each SHALL be 0 outside READ and WRITE respectively.
REQ-027 mem_addr SHALL be 0 and mem_wdata SHALL be 0 when the memory is idle.
REQ-028 The ALU output ports SHALL be 0 outside EXEC.
REQ-029 flags_wr_en SHALL load flags_wr_data in any state; if it coincides with an EXEC update where alu_write_flags=1, the ALU value SHALL win.
REQ-030 The flags register SHALL latch all 16 bits unchanged, with no masking.
REQ-031 req_valid SHALL be ignored outside IDLE; a request held across busy cycles SHALL be accepted on the first IDLE edge.
REQ-032 done SHALL pulse exactly once per accepted request, whether store is 0 or 1.

Reset
REQ-033 On reset: state=IDLE, flags=0, all latched operands=0, done=0, mem_read=0, mem_write=0, req_ready=1 in the following cycle.
REQ-034 Reset asserted in any state SHALL abort the operation: no mem_write, no flags update and no done pulse may follow.
REQ-035 Reset SHALL take priority over flags_wr_en and over request accept.

Verification
REQ-036 Full-path ADD: flags=0, op=A, src=0x0003, dst_addr=0x0010 where mem[0x10]=0xFFFE, store=1 -> mem_write of 0x0001 at 0x10 four cycles after accept; flags[2:0]=3'b100 (carry=1, negative=0, zero=0).
REQ-037 Fast-path COPY: op=0, src=0x1234, store=1 -> no mem_read; mem_write of 0x1234 two cycles after accept; flags unchanged (alu_write_flags=0).
REQ-038 Flags-only SUB: op=B, src=5, mem[dst]=5, store=0 -> done pulses, mem_write stays 0, flags[0]=1.
REQ-039 Collision: flags_wr_en=1 with data 0xFFFF in the EXEC cycle of an AND producing 0 -> flags equal the ALU flags_out, not 0xFFFF.
REQ-040 Reset asserted during WAIT -> IDLE next cycle, flags=0, and no mem_write or done for the aborted request.
REQ-041 Back-to-back: req_valid held high for two requests -> second accepted exactly 5 cycles after the first (full path), two done pulses.
